// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types, digit positions and 7-segment patterns for the
//               MM:SS stopwatch display controller.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // One BCD digit and one display scan position
    typedef logic [3:0] bcd_t;
    typedef logic [1:0] scan_idx_t;

    // Run/pause state of the counter
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } run_state_t;

    // Digit positions on the display, an[0] is the rightmost digit
    localparam scan_idx_t C_POS_SEC_ONES = 2'd0;
    localparam scan_idx_t C_POS_SEC_TENS = 2'd1;
    localparam scan_idx_t C_POS_MIN_ONES = 2'd2;
    localparam scan_idx_t C_POS_MIN_TENS = 2'd3;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] C_SEG_0     = 7'h3F;
    localparam logic [6:0] C_SEG_1     = 7'h06;
    localparam logic [6:0] C_SEG_2     = 7'h5B;
    localparam logic [6:0] C_SEG_3     = 7'h4F;
    localparam logic [6:0] C_SEG_4     = 7'h66;
    localparam logic [6:0] C_SEG_5     = 7'h6D;
    localparam logic [6:0] C_SEG_6     = 7'h7D;
    localparam logic [6:0] C_SEG_7     = 7'h07;
    localparam logic [6:0] C_SEG_8     = 7'h7F;
    localparam logic [6:0] C_SEG_9     = 7'h6F;
    localparam logic [6:0] C_SEG_DASH  = 7'h40;
    localparam logic [6:0] C_SEG_BLANK = 7'h00;

    // Digit to active-high pattern; anything above 9 shows a dash
    function automatic logic [6:0] seg_decode(input bcd_t digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = C_SEG_0;
            4'd1:    pattern = C_SEG_1;
            4'd2:    pattern = C_SEG_2;
            4'd3:    pattern = C_SEG_3;
            4'd4:    pattern = C_SEG_4;
            4'd5:    pattern = C_SEG_5;
            4'd6:    pattern = C_SEG_6;
            4'd7:    pattern = C_SEG_7;
            4'd8:    pattern = C_SEG_8;
            4'd9:    pattern = C_SEG_9;
            default: pattern = C_SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_display_ctrl_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module      : strobe_gen
// Description : Clock-enable strobe divider. Emits a one-cycle tick each time
//               the count reaches DIV-1; the count holds while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 1) begin : g_bad_div
            $error("strobe_gen: DIV must be at least 1");
        end
    endgenerate

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_last;

    assign at_last = (count_q == C_LAST);
    assign tick    = en & at_last;

    // Next count: clear wins, otherwise advance and wrap while enabled
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = at_last ? '0 : count_q + 1'b1;
        end
    end

    // Divider count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_display_ctrl
// Description : MM:SS stopwatch with run/pause, clear, per-field adjust with
//               blinking and a multiplexed 4-digit 7-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_display_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = 1,
    parameter int ADJ_HZ         = 2,
    parameter int BLINK_HZ       = 4,
    parameter int REFRESH_DIV    = 100_000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pause_tgl,
    input  logic        clr,
    input  logic        adj,
    input  logic        sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [15:0] time_bcd,
    output logic        running
);

    localparam int   SEC_DIV   = CLK_HZ / TICK_HZ;
    localparam int   ADJ_DIV   = CLK_HZ / ADJ_HZ;
    localparam int   BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam logic C_INV     = (SEG_ACTIVE_LOW != 0);

    logic sec_tick;
    logic adj_tick;
    logic blink_tick;
    logic scan_tick;

    // The count-rate divider freezes during adjust so counting resumes from
    // where it left off; the adjust divider only runs while adjusting.
    strobe_gen #(.DIV(SEC_DIV)) u_sec_strobe (
        .clk(clk), .rst_n(rst_n), .en(~adj), .clr(clr), .tick(sec_tick)
    );
    strobe_gen #(.DIV(ADJ_DIV)) u_adj_strobe (
        .clk(clk), .rst_n(rst_n), .en(adj), .clr(clr), .tick(adj_tick)
    );
    strobe_gen #(.DIV(BLINK_DIV)) u_blink_strobe (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .tick(blink_tick)
    );
    strobe_gen #(.DIV(REFRESH_DIV)) u_scan_strobe (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .clr(1'b0), .tick(scan_tick)
    );

    run_state_t state_q, state_d;
    bcd_t       sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    bcd_t       sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
    logic       sec_at_59, sec_inc, min_inc;
    scan_idx_t  scan_idx_q, scan_idx_d;
    logic       blink_phase_q, blink_phase_d;
    logic [3:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q, dp_d;
    bcd_t       digit;
    logic       in_sec_field, blank;
    logic [6:0] pattern;

    // Run/pause next state and the running flag
    always_comb begin
        state_d = state_q;
        running = (state_q == ST_RUN);
        if (pause_tgl) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
    end

    // Run/pause state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Field increment requests; adj_tick only fires in adjust mode and
    // sec_tick only outside it, so the two sources never overlap. The tick
    // sees the pre-toggle run state.
    assign sec_at_59 = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
    assign sec_inc   = (adj_tick & sel) | (sec_tick & running);
    assign min_inc   = (adj_tick & ~sel) | (sec_tick & running & sec_at_59);

    // Next time value: clear first, then independent seconds/minutes wraps
    always_comb begin
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        if (clr) begin
            sec_ones_d = '0;
            sec_tens_d = '0;
            min_ones_d = '0;
            min_tens_d = '0;
        end else begin
            if (sec_inc) begin
                if (sec_ones_q == 4'd9) begin
                    sec_ones_d = 4'd0;
                    sec_tens_d = (sec_tens_q == 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
                end else begin
                    sec_ones_d = sec_ones_q + 4'd1;
                end
            end
            if (min_inc) begin
                if (min_ones_q == 4'd9) begin
                    min_ones_d = 4'd0;
                    min_tens_d = (min_tens_q == 4'd9) ? 4'd0 : min_tens_q + 4'd1;
                end else begin
                    min_ones_d = min_ones_q + 4'd1;
                end
            end
        end
    end

    // Scan position and blink phase stepping
    always_comb begin
        scan_idx_d    = scan_tick ? scan_idx_q + 2'd1 : scan_idx_q;
        blink_phase_d = blink_tick ? ~blink_phase_q : blink_phase_q;
    end

    // Pin values for the current scan position; an, seg and dp are computed
    // together so the registered pins always belong to the same digit.
    always_comb begin
        case (scan_idx_q)
            C_POS_SEC_ONES: digit = sec_ones_q;
            C_POS_SEC_TENS: digit = sec_tens_q;
            C_POS_MIN_ONES: digit = min_ones_q;
            default:        digit = min_tens_q;
        endcase
        in_sec_field = (scan_idx_q == C_POS_SEC_ONES) || (scan_idx_q == C_POS_SEC_TENS);
        blank        = adj && !blink_phase_q && (sel == in_sec_field);
        pattern      = blank ? C_SEG_BLANK : seg_decode(digit);
        seg_d        = pattern ^ {7{C_INV}};
        an_d         = (4'b0001 << scan_idx_q) ^ {4{C_INV}};
        dp_d         = (scan_idx_q == C_POS_MIN_ONES) ^ C_INV;
    end

    // Time, scan, blink and output pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_ones_q    <= '0;
            sec_tens_q    <= '0;
            min_ones_q    <= '0;
            min_tens_q    <= '0;
            scan_idx_q    <= '0;
            blink_phase_q <= 1'b1;
            an_q          <= {4{C_INV}};
            seg_q         <= {7{C_INV}};
            dp_q          <= C_INV;
        end else begin
            sec_ones_q    <= sec_ones_d;
            sec_tens_q    <= sec_tens_d;
            min_ones_q    <= min_ones_d;
            min_tens_q    <= min_tens_d;
            scan_idx_q    <= scan_idx_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = dp_q;
    assign time_bcd = {min_tens_q, min_ones_q, sec_tens_q, sec_ones_q};

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_display_ctrl
// Description : Self-checking bench for stopwatch_display_ctrl with a
//               cycle-level behavioural model built on whole minutes/seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_display_ctrl;

    localparam int CLK_HZ      = 100;
    localparam int TICK_HZ     = 10;
    localparam int ADJ_HZ      = 20;
    localparam int BLINK_HZ    = 5;
    localparam int REFRESH_DIV = 2;
    localparam int SEC_DIV     = CLK_HZ / TICK_HZ;
    localparam int ADJ_DIV     = CLK_HZ / ADJ_HZ;
    localparam int BLINK_DIV   = CLK_HZ / (2 * BLINK_HZ);
    localparam logic [6:0] PATT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pause_tgl = 1'b0;
    logic        clr = 1'b0;
    logic        adj = 1'b0;
    logic        sel = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [15:0] time_bcd;
    logic        running;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int   m_min, m_sec, m_sec_cnt, m_adj_cnt, m_blink_cnt, m_scan_cnt, m_idx;
    bit   m_run, m_blink, m_last_blank;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;

    stopwatch_display_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .ADJ_HZ(ADJ_HZ),
        .BLINK_HZ(BLINK_HZ), .REFRESH_DIV(REFRESH_DIV), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pause_tgl(pause_tgl), .clr(clr),
        .adj(adj), .sel(sel), .seg(seg), .dp(dp), .an(an),
        .time_bcd(time_bcd), .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] exp_time();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_run = 1'b1;
        m_sec_cnt = 0; m_adj_cnt = 0; m_blink_cnt = 0; m_scan_cnt = 0;
        m_idx = 0; m_blink = 1'b1; m_last_blank = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    endtask

    // One clock edge: advance the model from the pre-edge view, then settle
    task automatic step();
        int  digit, total;
        bit  st, at, field_sec, blank;
        @(posedge clk);
        case (m_idx)
            0:       digit = m_sec % 10;
            1:       digit = m_sec / 10;
            2:       digit = m_min % 10;
            default: digit = m_min / 10;
        endcase
        field_sec    = (m_idx < 2);
        blank        = adj && !m_blink && (sel == field_sec);
        m_last_blank = blank;
        e_an  = ~(4'b0001 << m_idx);
        e_seg = blank ? 7'h7F : ~PATT[digit];
        e_dp  = (m_idx != 2);
        st = !adj && (m_sec_cnt == SEC_DIV - 1);
        at = adj && (m_adj_cnt == ADJ_DIV - 1);
        if (clr) begin
            m_min = 0; m_sec = 0;
        end else if (at) begin
            if (sel) m_sec = (m_sec + 1) % 60;
            else     m_min = (m_min + 1) % 100;
        end else if (st && m_run) begin
            total = (m_min * 60 + m_sec + 1) % 6000;
            m_min = total / 60;
            m_sec = total % 60;
        end
        if (pause_tgl) m_run = !m_run;
        if (clr) m_sec_cnt = 0; else if (!adj) m_sec_cnt = (m_sec_cnt + 1) % SEC_DIV;
        if (clr) m_adj_cnt = 0; else if (adj) m_adj_cnt = (m_adj_cnt + 1) % ADJ_DIV;
        if (m_blink_cnt == BLINK_DIV - 1) m_blink = !m_blink;
        m_blink_cnt = (m_blink_cnt + 1) % BLINK_DIV;
        if (m_scan_cnt == REFRESH_DIV - 1) m_idx = (m_idx + 1) % 4;
        m_scan_cnt = (m_scan_cnt + 1) % REFRESH_DIV;
        #1;
    endtask

    // Stimulus only: clear, then walk the fields up with adjust ticks
    task automatic preload(input int mins, input int secs);
        clr = 1'b1; step(); clr = 1'b0;
        adj = 1'b1; sel = 1'b0;
        repeat (mins * ADJ_DIV) step();
        sel = 1'b1;
        repeat (secs * ADJ_DIV) step();
        adj = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (time_bcd !== 16'h0000) begin failures++; $display("FAIL reset_time actual=%h required=%h", time_bcd, 16'h0000); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL reset_running actual=%b required=1", running); end
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL reset_an actual=%b required=1111", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg actual=%h required=7f", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL reset_dp actual=%b required=1", dp); end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_count();
        repeat (9) step();
        checks++; if (time_bcd !== 16'h0000) begin failures++; $display("FAIL count_9cyc actual=%h required=0000", time_bcd); end
        step();
        checks++; if (time_bcd !== 16'h0001) begin failures++; $display("FAIL count_10cyc actual=%h required=0001", time_bcd); end
        checks++; if (time_bcd !== exp_time()) begin failures++; $display("FAIL count_model actual=%h required=%h", time_bcd, exp_time()); end
    endtask

    task automatic test_wrap();
        preload(0, 59);
        checks++; if (time_bcd !== 16'h0059) begin failures++; $display("FAIL preload_59 actual=%h required=0059", time_bcd); end
        repeat (SEC_DIV) step();
        checks++; if (time_bcd !== 16'h0100) begin failures++; $display("FAIL wrap_sec actual=%h required=0100", time_bcd); end
        preload(99, 59);
        checks++; if (time_bcd !== 16'h9959) begin failures++; $display("FAIL preload_9959 actual=%h required=9959", time_bcd); end
        repeat (SEC_DIV) step();
        checks++; if (time_bcd !== 16'h0000) begin failures++; $display("FAIL wrap_all actual=%h required=0000", time_bcd); end
    endtask

    task automatic test_pause();
        int n;
        clr = 1'b1; step(); clr = 1'b0;
        repeat (14) step();
        pause_tgl = 1'b1; step(); pause_tgl = 1'b0;
        repeat (100) step();
        checks++; if (time_bcd !== 16'h0001) begin failures++; $display("FAIL pause_hold actual=%h required=0001", time_bcd); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_running actual=%b required=0", running); end
        pause_tgl = 1'b1; step(); pause_tgl = 1'b0;
        repeat (SEC_DIV) step();
        checks++; if (time_bcd !== 16'h0002) begin failures++; $display("FAIL resume_count actual=%h required=0002", time_bcd); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL resume_running actual=%b required=1", running); end
        n = 0;
        while (m_sec_cnt != SEC_DIV - 1 && n < 2 * SEC_DIV) begin step(); n++; end
        checks++; if (m_sec_cnt != SEC_DIV - 1) begin failures++; $display("FAIL pause_align actual=%0d required=%0d", m_sec_cnt, SEC_DIV - 1); end
        pause_tgl = 1'b1; step(); pause_tgl = 1'b0;
        checks++; if (time_bcd !== 16'h0003) begin failures++; $display("FAIL pause_coincident actual=%h required=0003", time_bcd); end
        checks++; if (running !== 1'b0) begin failures++; $display("FAIL pause_coincident_run actual=%b required=0", running); end
        pause_tgl = 1'b1; step(); pause_tgl = 1'b0;
        checks++; if (running !== m_run) begin failures++; $display("FAIL pause_rerun actual=%b required=%b", running, m_run); end
    endtask

    task automatic test_adjust_sec();
        int blanks;
        preload(0, 58);
        checks++; if (time_bcd !== 16'h0058) begin failures++; $display("FAIL preload_58 actual=%h required=0058", time_bcd); end
        adj = 1'b1; sel = 1'b1; blanks = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++; if (time_bcd !== exp_time()) begin failures++; $display("FAIL adjsec_time cyc=%0d actual=%h required=%h", i, time_bcd, exp_time()); end
            checks++; if (seg !== e_seg) begin failures++; $display("FAIL adjsec_seg cyc=%0d actual=%h required=%h", i, seg, e_seg); end
            if (m_last_blank && seg === 7'h7F) blanks++;
            if (i == 9) begin
                checks++; if (time_bcd !== 16'h0000) begin failures++; $display("FAIL adjsec_wrap actual=%h required=0000", time_bcd); end
            end
        end
        checks++; if (blanks == 0) begin failures++; $display("FAIL adjsec_blink actual=%0d blanked_cycles required=nonzero", blanks); end
        checks++; if (time_bcd !== 16'h0004) begin failures++; $display("FAIL adjsec_end actual=%h required=0004", time_bcd); end
        adj = 1'b0;
    endtask

    task automatic test_adjust_min();
        preload(99, 30);
        checks++; if (time_bcd !== 16'h9930) begin failures++; $display("FAIL preload_9930 actual=%h required=9930", time_bcd); end
        adj = 1'b1; sel = 1'b0;
        repeat (ADJ_DIV) step();
        checks++; if (time_bcd !== 16'h0030) begin failures++; $display("FAIL adjmin_wrap actual=%h required=0030", time_bcd); end
        for (int i = 0; i < 3 * SEC_DIV; i++) begin
            step();
            checks++; if (time_bcd[7:0] !== 8'h30) begin failures++; $display("FAIL adjmin_sec_hold cyc=%0d actual=%h required=30", i, time_bcd[7:0]); end
            checks++; if (seg !== e_seg) begin failures++; $display("FAIL adjmin_seg cyc=%0d actual=%h required=%h", i, seg, e_seg); end
        end
        checks++; if (time_bcd !== 16'h0630) begin failures++; $display("FAIL adjmin_end actual=%h required=0630", time_bcd); end
        adj = 1'b0;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 16; i++) begin
            step();
            checks++; if (an !== e_an) begin failures++; $display("FAIL scan_an cyc=%0d actual=%b required=%b", i, an, e_an); end
            checks++; if (seg !== e_seg) begin failures++; $display("FAIL scan_seg cyc=%0d actual=%h required=%h", i, seg, e_seg); end
            checks++; if ((dp === 1'b0) !== (an === 4'b1011)) begin failures++; $display("FAIL scan_dp cyc=%0d actual=dp%b/an%b required=dp0_only_at_1011", i, dp, an); end
        end
    endtask

    task automatic test_clr_tick();
        int n;
        if (!m_run) begin pause_tgl = 1'b1; step(); pause_tgl = 1'b0; end
        repeat (2 * SEC_DIV + 3) step();
        n = 0;
        while (m_sec_cnt != SEC_DIV - 1 && n < 2 * SEC_DIV) begin step(); n++; end
        checks++; if (time_bcd === 16'h0000) begin failures++; $display("FAIL clr_precond actual=%h required=nonzero", time_bcd); end
        clr = 1'b1; step(); clr = 1'b0;
        checks++; if (time_bcd !== 16'h0000) begin failures++; $display("FAIL clr_tick actual=%h required=0000", time_bcd); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL clr_running actual=%b required=1", running); end
        repeat (SEC_DIV) step();
        checks++; if (time_bcd !== 16'h0001) begin failures++; $display("FAIL clr_divider actual=%h required=0001", time_bcd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            pause_tgl = ($urandom_range(0, 15) == 0);
            clr       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) adj = ~adj;
            if ($urandom_range(0, 29) == 0) sel = 1'($urandom_range(0, 1));
            step();
            checks++; if (time_bcd !== exp_time()) begin failures++; $display("FAIL rand_time cyc=%0d actual=%h required=%h", i, time_bcd, exp_time()); end
            checks++; if (running !== m_run) begin failures++; $display("FAIL rand_running cyc=%0d actual=%b required=%b", i, running, m_run); end
            checks++; if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin failures++; $display("FAIL rand_pins cyc=%0d actual=%b/%h/%b required=%b/%h/%b", i, an, seg, dp, e_an, e_seg, e_dp); end
        end
        pause_tgl = 1'b0; clr = 1'b0; adj = 1'b0; sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        preload(12, 34);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF) begin failures++; $display("FAIL async_an actual=%b required=1111", an); end
        checks++; if (seg !== 7'h7F) begin failures++; $display("FAIL async_seg actual=%h required=7f", seg); end
        checks++; if (dp !== 1'b1) begin failures++; $display("FAIL async_dp actual=%b required=1", dp); end
        checks++; if (time_bcd !== 16'h0000) begin failures++; $display("FAIL async_time actual=%h required=0000", time_bcd); end
        checks++; if (running !== 1'b1) begin failures++; $display("FAIL async_running actual=%b required=1", running); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < SEC_DIV; i++) begin
            step();
            checks++; if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin failures++; $display("FAIL post_reset_pins cyc=%0d actual=%b/%h/%b required=%b/%h/%b", i, an, seg, dp, e_an, e_seg, e_dp); end
        end
        checks++; if (time_bcd !== 16'h0001) begin failures++; $display("FAIL post_reset_count actual=%h required=0001", time_bcd); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_adjust_sec();
        test_adjust_min();
        test_scan();
        test_clr_tick();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
